// File: rtl/alu_md_controller_if.sv
// ALU control / multiply-divide handshake bundle.
// master: instruction-side driver (decode fields, operands, valid/flush);
//         receives the ALU operation select and the md engine status/result.
// slave : alu_md_controller side of the same signals.
interface alu_md_controller_if #(
   parameter int unsigned DATA_W = 32
);
   logic [1:0]        alu_op;
   logic [6:0]        funct7;
   logic [2:0]        funct3;
   logic              valid_i;
   logic              flush_i;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic [3:0]        operation;
   logic              md_busy;
   logic              md_done;
   logic [DATA_W-1:0] md_result;

   modport master (
      output alu_op, funct7, funct3, valid_i, flush_i, src_a, src_b,
      input  operation, md_busy, md_done, md_result
   );

   modport slave (
      input  alu_op, funct7, funct3, valid_i, flush_i, src_a, src_b,
      output operation, md_busy, md_done, md_result
   );
endinterface

// File: rtl/alu_md_controller.sv
// ALU operation decoder plus iterative RV32M-style multiply/divide engine.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - alu_md_controller_if.slave:
//           in : alu_op, funct7, funct3, valid_i, flush_i, src_a, src_b
//           out: operation (comb ALU select), md_busy (stall request),
//                md_done (one-cycle completion pulse), md_result
module alu_md_controller #(
   parameter int unsigned DATA_W = 32,
   parameter bit          EN_MD  = 1'b1
) (
   input logic              clk,
   input logic              reset,
   alu_md_controller_if.slave bus
);
   localparam int unsigned CW = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [2:0]        op_q;
   logic              sa_q, sb_q;
   logic [DATA_W-1:0] m_q;      // multiplicand (mul) or divisor (div) magnitude
   logic [DATA_W-1:0] hi, lo;   // product high/low, or remainder/quotient
   logic [DATA_W-1:0] res_q;    // result of the op sitting in DONE
   logic [DATA_W-1:0] hold_q;   // last retired result

   logic [3:0]          op_c;
   logic                md_req;
   logic                a_sgn, b_sgn, sa, sb;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [DATA_W:0]     sum, shl;
   logic                ge;
   logic [DATA_W-1:0]   hi_n, lo_n, res_n;
   logic [2*DATA_W-1:0] prod, prod_s;

   // ALU operation select, purely combinational
   always_comb begin
      op_c = 4'b0000;
      case (bus.alu_op)
         2'b00: op_c = 4'b0010;
         2'b11: op_c = 4'b1101;
         2'b01: begin
            case (bus.funct3)
               3'b000:  op_c = 4'b1000;
               3'b001:  op_c = 4'b1001;
               3'b100:  op_c = 4'b1010;
               3'b101:  op_c = 4'b1011;
               default: op_c = 4'b0000;
            endcase
         end
         default: begin
            if (bus.funct7 != 7'b0000001) begin
               case (bus.funct3)
                  3'b000:  op_c = (bus.funct7 == 7'b0100000) ? 4'b0101 : 4'b0010;
                  3'b001:  op_c = 4'b0011;
                  3'b010:  op_c = 4'b0111;
                  3'b100:  op_c = 4'b1100;
                  3'b101:  op_c = (bus.funct7 == 7'b0100000) ? 4'b0110 : 4'b0100;
                  3'b110:  op_c = 4'b0001;
                  default: op_c = 4'b0000;
               endcase
            end
         end
      endcase
   end

   assign md_req = EN_MD && bus.valid_i && !bus.flush_i &&
                   (bus.alu_op == 2'b10) && (bus.funct7 == 7'b0000001);

   // Operand sign handling: the engine works on magnitudes only
   always_comb begin
      a_sgn = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
              (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      b_sgn = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
              (bus.funct3 == 3'b110);
      sa    = a_sgn && bus.src_a[DATA_W-1];
      sb    = b_sgn && bus.src_b[DATA_W-1];
      a_mag = sa ? -bus.src_a : bus.src_a;
      b_mag = sb ? -bus.src_b : bus.src_b;
   end

   // One iteration: shift-add multiply or restoring divide step
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
      shl  = {hi, lo[DATA_W-1]};
      ge   = shl >= {1'b0, m_q};
      if (op_q[2]) begin
         hi_n = ge ? DATA_W'(shl - {1'b0, m_q}) : shl[DATA_W-1:0];
         lo_n = {lo[DATA_W-2:0], ge};
      end else begin
         hi_n = sum[DATA_W:1];
         lo_n = {sum[0], lo[DATA_W-1:1]};
      end
   end

   // Sign fix-up and result selection on the final iteration
   always_comb begin
      prod   = {hi_n, lo_n};
      prod_s = (sa_q ^ sb_q) ? -prod : prod;
      res_n  = '0;
      case (op_q)
         3'b000:        res_n = prod_s[DATA_W-1:0];
         3'b001, 3'b010,
         3'b011:        res_n = prod_s[2*DATA_W-1:DATA_W];
         3'b100, 3'b101: begin
            if (m_q == '0) res_n = '1;
            else           res_n = (sa_q ^ sb_q) ? -lo_n : lo_n;
         end
         default:       res_n = sa_q ? -hi_n : hi_n;
      endcase
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         m_q    <= '0;
         hi     <= '0;
         lo     <= '0;
         res_q  <= '0;
         hold_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (md_req) begin
                  op_q  <= bus.funct3;
                  sa_q  <= sa;
                  sb_q  <= sb;
                  m_q   <= bus.funct3[2] ? b_mag : a_mag;
                  lo    <= bus.funct3[2] ? a_mag : b_mag;
                  hi    <= '0;
                  cnt   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               if (bus.flush_i) begin
                  state <= IDLE;
               end else begin
                  hi  <= hi_n;
                  lo  <= lo_n;
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(DATA_W - 1)) begin
                     res_q <= res_n;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               // a flushed op retires without publishing its result
               if (!bus.flush_i) hold_q <= res_q;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.operation = op_c;
   assign bus.md_busy   = (state == CALC) || ((state == IDLE) && md_req);
   assign bus.md_done   = (state == DONE) && !bus.flush_i;
   assign bus.md_result = bus.md_done ? res_q : hold_q;

endmodule

// File: tb/tb_alu_md_controller.sv
// Directed bench for alu_md_controller (DATA_W=32): ALU decode table,
// multiply/divide results and latency, flush, reset mid-op, held request.
module tb_alu_md_controller;
   localparam int unsigned DATA_W = 32;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_md_controller_if #(.DATA_W(DATA_W)) bus ();

   alu_md_controller #(.DATA_W(DATA_W), .EN_MD(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bus.valid_i = 1'b1;
      bus.flush_i = 1'b0;
      bus.alu_op  = 2'b10;
      bus.funct7  = 7'b0000001;
      bus.funct3  = f3;
      bus.src_a   = a;
      bus.src_b   = b;
   endtask

   task automatic dec(input string tag, input logic [1:0] op, input logic [6:0] f7,
                      input logic [2:0] f3, input logic [3:0] exp);
      bus.valid_i = 1'b0;
      bus.alu_op  = op;
      bus.funct7  = f7;
      bus.funct3  = f3;
      #1;
      check(tag, 64'(bus.operation), 64'(exp));
   endtask

   // Full op: busy in C..C+32, done only in C+33, result held afterwards
   task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      step();
      drive_md(f3, a, b);
      @(negedge clk);
      check({tag, "_busy_accept"}, 64'(bus.md_busy), 64'd1);
      check({tag, "_done_accept"}, 64'(bus.md_done), 64'd0);
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i == 1) begin
            bus.valid_i = 1'b0;
            bus.src_a   = ~a;
            bus.src_b   = a ^ b ^ 32'h5a5a_a5a5;
         end
         @(negedge clk);
         check({tag, "_busy_calc"}, 64'(bus.md_busy), 64'd1);
         check({tag, "_done_calc"}, 64'(bus.md_done), 64'd0);
      end
      step();
      @(negedge clk);
      check({tag, "_done"}, 64'(bus.md_done), 64'd1);
      check({tag, "_busy_done"}, 64'(bus.md_busy), 64'd0);
      check({tag, "_result"}, 64'(bus.md_result), 64'(exp));
      step();
      @(negedge clk);
      check({tag, "_done_after"}, 64'(bus.md_done), 64'd0);
      check({tag, "_result_hold"}, 64'(bus.md_result), 64'(exp));
   endtask

   initial begin
      int ndone;
      reset       = 1'b1;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.alu_op  = 2'b11;
      bus.funct7  = 7'd0;
      bus.funct3  = 3'd0;
      bus.src_a   = '0;
      bus.src_b   = '0;
      #12;
      check("rst_operation", 64'(bus.operation), 64'b1101);
      check("rst_busy", 64'(bus.md_busy), 64'd0);
      check("rst_done", 64'(bus.md_done), 64'd0);
      check("rst_result", 64'(bus.md_result), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      dec("dec_lw",    2'b00, 7'h00, 3'b111, 4'b0010);
      dec("dec_jal",   2'b11, 7'h20, 3'b000, 4'b1101);
      dec("dec_beq",   2'b01, 7'h00, 3'b000, 4'b1000);
      dec("dec_bne",   2'b01, 7'h00, 3'b001, 4'b1001);
      dec("dec_blt",   2'b01, 7'h00, 3'b100, 4'b1010);
      dec("dec_bge",   2'b01, 7'h00, 3'b101, 4'b1011);
      dec("dec_br010", 2'b01, 7'h00, 3'b010, 4'b0000);
      dec("dec_add",   2'b10, 7'h00, 3'b000, 4'b0010);
      dec("dec_sub",   2'b10, 7'h20, 3'b000, 4'b0101);
      dec("dec_sll",   2'b10, 7'h00, 3'b001, 4'b0011);
      dec("dec_slt",   2'b10, 7'h00, 3'b010, 4'b0111);
      dec("dec_sltu",  2'b10, 7'h00, 3'b011, 4'b0000);
      dec("dec_xor",   2'b10, 7'h00, 3'b100, 4'b1100);
      dec("dec_srl",   2'b10, 7'h00, 3'b101, 4'b0100);
      dec("dec_sra",   2'b10, 7'h20, 3'b101, 4'b0110);
      dec("dec_or",    2'b10, 7'h00, 3'b110, 4'b0001);
      dec("dec_and",   2'b10, 7'h00, 3'b111, 4'b0000);
      dec("dec_mdop",  2'b10, 7'h01, 3'b000, 4'b0000);
      dec("dec_mdop6", 2'b10, 7'h01, 3'b110, 4'b0000);
      check("idle_busy", 64'(bus.md_busy), 64'd0);

      run_md("mul",     3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
      run_md("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_md("mulh",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      run_md("div",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
      run_md("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
      run_md("divu",    3'b101, 32'd100,       32'd7,         32'd14);
      run_md("divu_z",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
      run_md("div_z",   3'b100, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF);
      run_md("rem_z",   3'b110, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0);
      run_md("remu_z",  3'b111, 32'd5,         32'd0,         32'd5);

      // Flush on the 10th CALC cycle
      step();
      drive_md(3'b000, 32'h1234, 32'h55);
      @(negedge clk);
      for (int i = 1; i <= 9; i++) begin
         step();
         if (i == 1) bus.valid_i = 1'b0;
      end
      step();
      bus.flush_i = 1'b1;
      @(negedge clk);
      check("flush_done_calc", 64'(bus.md_done), 64'd0);
      step();
      bus.flush_i = 1'b0;
      @(negedge clk);
      check("flush_busy_after", 64'(bus.md_busy), 64'd0);
      check("flush_done_after", 64'(bus.md_done), 64'd0);
      check("flush_result_hold", 64'(bus.md_result), 64'd5);
      for (int i = 0; i < 30; i++) begin
         step();
         @(negedge clk);
         check("flush_no_done", 64'(bus.md_done), 64'd0);
      end
      run_md("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12);
      run_md("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_md("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      run_md("mulsu_a", 3'b010, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);

      // Reset pulse between edges while in CALC
      step();
      drive_md(3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      @(negedge clk);
      for (int i = 1; i <= 5; i++) begin
         step();
         if (i == 1) bus.valid_i = 1'b0;
      end
      #2;
      reset = 1'b1;
      #1;
      check("rstmid_busy", 64'(bus.md_busy), 64'd0);
      check("rstmid_done", 64'(bus.md_done), 64'd0);
      check("rstmid_result", 64'(bus.md_result), 64'd0);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rstmid_busy_after", 64'(bus.md_busy), 64'd0);
      run_md("divu_rst", 3'b101, 32'd100, 32'd7, 32'd14);

      // Request held through DONE: one pulse per op, re-accept only after DONE
      ndone = 0;
      step();
      drive_md(3'b010, 32'hFFFF_FFFF, 32'd2);
      for (int i = 0; i <= 67; i++) begin
         if (i > 0) step();
         if (i == 35) bus.valid_i = 1'b0;
         @(negedge clk);
         if (bus.md_done) ndone++;
         if (i == 33) begin
            check("held_done1", 64'(bus.md_done), 64'd1);
            check("held_busy_done", 64'(bus.md_busy), 64'd0);
            check("held_result1", 64'(bus.md_result), 64'hFFFF_FFFF);
         end
         if (i == 34) check("held_reaccept", 64'(bus.md_busy), 64'd1);
         if (i == 67) begin
            check("held_done2", 64'(bus.md_done), 64'd1);
            check("held_result2", 64'(bus.md_result), 64'hFFFF_FFFF);
         end
      end
      check("held_done_count", 64'(ndone), 64'd2);
      step();
      @(negedge clk);
      check("held_idle_busy", 64'(bus.md_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
